imem_fetch_unit: RTL and testbench

- Parametrised synchronous instruction memory for the single-cycle CPU and its successors. Adds a clocked read with a request/response handshake and back-pressure.
- Adds a programming port so a loader can write the program at run time, replacing compile-time contents.
- Out-of-range fetches return a NOP word and raise a fault flag, so the core can trap instead of executing garbage.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_array.sv | 28 ++
 rtl/imem_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_imem_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch unit.
// Imported by the RAM array and the fetch unit.
package imem_pkg;

  typedef enum logic {
    RUN,
    PROG
  } state_e;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W RAM: one sync write port, one sync read port with enable.
// No reset on storage so it maps onto block RAM.
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Clocked instruction fetch with valid/ready handshake, fault on
// out-of-range fetch, and a run-time programming port.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 13,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_active,
  output logic              prog_err,
  output logic [ADDR_W:0]   prog_count
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e state_q;
  state_e state_d;

  logic              fetch_ok;
  logic              prog_ok;
  logic              accept;
  logic              consume;
  logic              rd_en;
  logic              wr_en;
  logic              enter_prog;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic              data_sel_q;
  logic              prog_err_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] rd_word;

  assign fetch_ok = {1'b0, fetch_addr} < DEPTH_C;
  assign prog_ok  = {1'b0, prog_addr} < DEPTH_C;

  assign fetch_ready = (state_q == RUN) && !prog_en
                    && (!rsp_valid_q || rsp_ready);
  assign accept  = fetch_req && fetch_ready;
  assign consume = rsp_valid_q && rsp_ready;
  assign rd_en   = accept && fetch_ok;
  assign wr_en   = (state_q == PROG) && prog_we && prog_ok;

  // Mode switch waits for the pending response to drain.
  always_comb begin
    state_d    = state_q;
    enter_prog = 1'b0;
    unique case (state_q)
      RUN: begin
        if (prog_en && !rsp_valid_q) begin
          state_d    = PROG;
          enter_prog = 1'b1;
        end
      end
      PROG: begin
        if (!prog_en) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // data_sel_q picks the RAM word; cleared means NOP_WORD is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      data_sel_q  <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_fault_q <= !fetch_ok;
      data_sel_q  <= fetch_ok;
    end else if (consume) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prog_err_q <= 1'b0;
    end else if (enter_prog) begin
      cnt_q      <= '0;
      prog_err_q <= 1'b0;
    end else if ((state_q == PROG) && prog_we) begin
      if (!prog_ok) begin
        prog_err_q <= 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (prog_addr[IDX_W-1:0]),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (rd_word)
  );

  assign rsp_valid   = rsp_valid_q;
  assign rsp_fault   = rsp_fault_q;
  assign rsp_data    = data_sel_q ? rd_word : NOP_WORD;
  assign prog_active = (state_q == PROG);
  assign prog_err    = prog_err_q;
  assign prog_count  = cnt_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed vector table, reset corners,
// and random traffic against a queue-based reference model.
module tb_imem_fetch_unit;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int DEP = 64;
  localparam logic [15:0] NOP = 16'h8000;

  logic          clk;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_fault;
  logic          prog_en;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_active;
  logic          prog_err;
  logic [AW:0]   prog_count;

  imem_fetch_unit #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEP),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_fault   (rsp_fault),
    .prog_en     (prog_en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_active (prog_active),
    .prog_err    (prog_err),
    .prog_count  (prog_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending responses as a queue, memory as an array.
  typedef struct {
    logic [15:0] data;
    logic        fault;
  } rsp_t;

  rsp_t        m_pend[$];
  logic [15:0] mm[DEP];
  bit          m_prog = 0;
  int          m_cnt = 0;
  bit          m_err = 0;

  task automatic model_reset();
    m_pend.delete();
    m_prog = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic step(input logic req, input logic [AW-1:0] a,
                      input logic rr, input logic pen, input logic pwe,
                      input logic [AW-1:0] pa, input logic [15:0] pd);
    bit   busy;
    logic exp_rdy;
    rsp_t r;
    fetch_req = req;
    fetch_addr = a;
    rsp_ready = rr;
    prog_en = pen;
    prog_we = pwe;
    prog_addr = pa;
    prog_data = pd;
    #1;
    busy = (m_pend.size() != 0);
    exp_rdy = !m_prog && !pen && (!busy || rr);
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_rdy));
    if (busy && rr) m_pend.pop_front();
    if (req && exp_rdy) begin
      r.fault = (a >= DEP);
      r.data = r.fault ? NOP : mm[a];
      m_pend.push_back(r);
    end
    if (m_prog) begin
      if (pwe) begin
        if (pa < DEP) begin
          mm[pa] = pd;
          if (m_cnt < (1 << AW)) m_cnt++;
        end else begin
          m_err = 1;
        end
      end
      if (!pen) m_prog = 0;
    end else if (pen && !busy) begin
      m_prog = 1;
      m_cnt = 0;
      m_err = 0;
    end
    @(posedge clk);
    #1;
    chk("m_valid", 32'(rsp_valid), 32'(m_pend.size() != 0));
    if (m_pend.size() != 0) begin
      chk("m_data", 32'(rsp_data), 32'(m_pend[0].data));
      chk("m_fault", 32'(rsp_fault), 32'(m_pend[0].fault));
    end
    chk("m_pact", 32'(prog_active), 32'(m_prog));
    chk("m_pcnt", 32'(prog_count), 32'(m_cnt));
    chk("m_perr", 32'(prog_err), 32'(m_err));
  endtask

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          rr;
    logic          pen;
    logic          pwe;
    logic [AW-1:0] pa;
    logic [15:0]   pd;
    logic          e_rdy;
    logic          e_val;
    logic [15:0]   e_dat;
    logic          e_flt;
    logic          e_pact;
    logic [AW:0]   e_cnt;
    logic          e_err;
  } vec_t;

  function automatic vec_t v(
    logic req, int addr, logic rr, logic pen, logic pwe, int pa,
    logic [15:0] pd, logic rdy, logic val, logic [15:0] dat,
    logic flt, logic pact, int cnt, logic err);
    vec_t t;
    t.req = req;  t.addr = AW'(addr); t.rr = rr;
    t.pen = pen;  t.pwe = pwe;        t.pa = AW'(pa);
    t.pd = pd;    t.e_rdy = rdy;      t.e_val = val;
    t.e_dat = dat; t.e_flt = flt;     t.e_pact = pact;
    t.e_cnt = (AW+1)'(cnt);           t.e_err = err;
    return t;
  endfunction

  vec_t tbl[$];
  logic rdy_pre;

  initial begin
    rst_n = 1'b0;
    fetch_req = 0; fetch_addr = '0; rsp_ready = 0;
    prog_en = 0; prog_we = 0; prog_addr = '0; prog_data = '0;

    #12;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 32'(NOP));
    chk("rst_fault", 32'(rsp_fault), 0);
    chk("rst_pact", 32'(prog_active), 0);
    chk("rst_perr", 32'(prog_err), 0);
    chk("rst_pcnt", 32'(prog_count), 0);
    chk("rst_ready", 32'(fetch_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // program, back-to-back fetch, back-pressure, fault
    tbl.push_back(v(0,0,0,1,0,0,0,         0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,1,1,0,16'hC00A,  0,0,0,0,1,1,0));
    tbl.push_back(v(0,0,0,1,1,1,16'h2000,  0,0,0,0,1,2,0));
    tbl.push_back(v(0,0,0,1,1,2,16'hC005,  0,0,0,0,1,3,0));
    tbl.push_back(v(1,0,1,0,0,0,0,         0,0,0,0,0,3,0));
    tbl.push_back(v(1,0,1,0,0,0,0,         1,1,16'hC00A,0,0,3,0));
    tbl.push_back(v(1,1,1,0,0,0,0,         1,1,16'h2000,0,0,3,0));
    tbl.push_back(v(1,2,1,0,0,0,0,         1,1,16'hC005,0,0,3,0));
    tbl.push_back(v(0,0,1,0,0,0,0,         1,0,0,0,0,3,0));
    tbl.push_back(v(1,1,0,0,0,0,0,         1,1,16'h2000,0,0,3,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1,0,0,0,0,0,0,       0,1,16'h2000,0,0,3,0));
    tbl.push_back(v(1,0,1,0,0,0,0,         1,1,16'hC00A,0,0,3,0));
    tbl.push_back(v(1,64,1,0,0,0,0,        1,1,NOP,1,0,3,0));
    tbl.push_back(v(1,0,1,0,0,0,0,         1,1,16'hC00A,0,0,3,0));
    tbl.push_back(v(0,0,1,0,0,0,0,         1,0,0,0,0,3,0));
    // bad write, re-entry clears
    tbl.push_back(v(0,0,0,1,0,0,0,         0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,1,1,100,16'h1234,0,0,0,0,1,0,1));
    tbl.push_back(v(0,0,0,1,1,3,16'h1111,  0,0,0,0,1,1,1));
    tbl.push_back(v(0,0,0,0,0,0,0,         0,0,0,0,0,1,1));
    tbl.push_back(v(0,0,0,1,0,0,0,         0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,         0,0,0,0,0,0,0));
    // mode arbitration against a stalled response
    tbl.push_back(v(1,2,0,0,0,0,0,         1,1,16'hC005,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,         0,1,16'hC005,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,         0,1,16'hC005,0,0,0,0));
    tbl.push_back(v(0,0,1,1,0,0,0,         0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,1,0,0,0,         0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,         0,0,0,0,0,0,0));
    // write strobe in RUN is ignored
    tbl.push_back(v(0,0,0,0,1,0,16'hFFFF,  1,0,0,0,0,0,0));
    tbl.push_back(v(1,0,1,0,0,0,0,         1,1,16'hC00A,0,0,0,0));
    tbl.push_back(v(1,3,1,0,0,0,0,         1,1,16'h1111,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,0,         1,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      fetch_req = tbl[i].req;
      prog_en = tbl[i].pen;
      rsp_ready = tbl[i].rr;
      #1;
      rdy_pre = fetch_ready;
      step(tbl[i].req, tbl[i].addr, tbl[i].rr, tbl[i].pen,
           tbl[i].pwe, tbl[i].pa, tbl[i].pd);
      chk($sformatf("v%0d_rdy", i), 32'(rdy_pre), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_val", i), 32'(rsp_valid), 32'(tbl[i].e_val));
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_dat", i), 32'(rsp_data), 32'(tbl[i].e_dat));
        chk($sformatf("v%0d_flt", i), 32'(rsp_fault), 32'(tbl[i].e_flt));
      end
      chk($sformatf("v%0d_pact", i), 32'(prog_active), 32'(tbl[i].e_pact));
      chk($sformatf("v%0d_cnt", i), 32'(prog_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_err", i), 32'(prog_err), 32'(tbl[i].e_err));
    end

    // async reset while a response is held
    step(1, 1, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_data", 32'(rsp_data), 32'(NOP));
    chk("arst_pact", 32'(prog_active), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 1, 0, 0, 0, 0);
    chk("arst_keep0", 32'(rsp_data), 32'h0000C00A);
    step(0, 0, 1, 0, 0, 0, 0);

    // async reset while programming keeps written words
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5, 16'h5555);
    #1;
    rst_n = 1'b0;
    prog_en = 0;
    prog_we = 0;
    #1;
    chk("prst_pact", 32'(prog_active), 0);
    chk("prst_pcnt", 32'(prog_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 5, 1, 0, 0, 0, 0);
    chk("prst_keep5", 32'(rsp_data), 32'h00005555);
    step(0, 0, 1, 0, 0, 0, 0);

    // fill memory, then random traffic
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DEP; i++)
      step(0, 0, 0, 1, 1, AW'(i), 16'($urandom));
    step(0, 0, 0, 0, 0, 0, 0);
    begin
      logic          pen_r;
      logic [AW-1:0] fa;
      pen_r = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) pen_r = !pen_r;
        fa = ($urandom_range(0, 7) == 0) ? AW'(13'h1FFF)
                                         : AW'($urandom_range(0, 79));
        step($urandom_range(0, 3) != 0, fa,
             $urandom_range(0, 2) != 0, pen_r,
             1'($urandom), AW'($urandom_range(0, 79)),
             16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
